// File: rtl/aq_mmu_smcir_rsp.sv
// aq_mmu_smcir_rsp: MMU-side responder for the CP0 MMU-maintenance CSRs.
// Holds smir/smeh/smel and a satp shadow; runs smcir commands on the jTLB port.
module aq_mmu_smcir_rsp #(
   parameter int ENTRIES  = 128,
   parameter int ENTRY_AW = 7,
   parameter int TLB_W    = 89
) (
   input  logic                forever_cpuclk,
   input  logic                cpurst,
   input  logic [63:0]         cp0_mmu_csr_wdata,
   input  logic                cp0_mmu_smcir_wen,
   input  logic                cp0_mmu_smir_wen,
   input  logic                cp0_mmu_smeh_wen,
   input  logic                cp0_mmu_smel_wen,
   input  logic                cp0_mmu_satp_wen,
   input  logic [63:0]         cp0_mmu_satp_data,
   input  logic [1:0]          cp0_mmu_csr_sel,
   output logic [63:0]         mmu_cp0_data,
   output logic                mmu_cp0_cmplt,
   output logic [15:0]         mmu_satp_asid,
   output logic [3:0]          mmu_satp_mode,
   output logic                mmu_tlb_req,
   output logic                mmu_tlb_wen,
   output logic [ENTRY_AW-1:0] mmu_tlb_idx,
   output logic [TLB_W-1:0]    mmu_tlb_wdata,
   input  logic                tlb_mmu_gnt,
   input  logic                tlb_mmu_rvalid,
   input  logic [TLB_W-1:0]    tlb_mmu_rdata
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ISSUE   = 2'd1;
   localparam logic [1:0] WAIT_RD = 2'd2;
   localparam logic [1:0] CMPLT   = 2'd3;

   localparam logic [2:0] OP_P  = 3'd0;
   localparam logic [2:0] OP_R  = 3'd1;
   localparam logic [2:0] OP_WI = 3'd2;
   localparam logic [2:0] OP_WR = 3'd3;
   localparam logic [2:0] OP_IA = 3'd4;
   localparam logic [2:0] OP_IS = 3'd5;

   localparam logic [ENTRY_AW-1:0] LAST = ENTRY_AW'(ENTRIES - 1);

   logic [1:0]          state_q, state_d;
   logic [2:0]          op_q, op_d;
   logic [ENTRY_AW-1:0] idx_q, idx_d;
   logic [ENTRY_AW-1:0] rnd_q;
   logic                wen_q, wen_d;
   logic [TLB_W-1:0]    wdat_q, wdat_d;
   logic [15:0]         opasid_q, opasid_d;
   logic [ENTRY_AW-1:0] sidx_q, sidx_d;
   logic                sp_q, sp_d;
   logic [15:0]         asid_q, asid_d;
   logic [2:0]          pgs_q, pgs_d;
   logic [26:0]         vpn_q, vpn_d;
   logic [27:0]         ppn_q, ppn_d;
   logic [13:0]         flg_q, flg_d;
   logic [15:0]         satp_asid_q;
   logic [3:0]          satp_mode_q;

   logic                r_vld;
   logic [26:0]         r_vpn;
   logic [15:0]         r_asid;
   logic                r_hit;
   logic                last;
   logic [TLB_W-1:0]    new_ent;
   logic [63:0]         w;
   logic                unused;

   assign w       = cp0_mmu_csr_wdata;
   assign r_vld   = tlb_mmu_rdata[88];
   assign r_vpn   = tlb_mmu_rdata[87:61];
   assign r_asid  = tlb_mmu_rdata[60:45];
   assign r_hit   = r_vld && (r_vpn == vpn_q) && (r_asid == asid_q);
   assign last    = (idx_q == LAST);
   assign new_ent = {1'b1, vpn_q, asid_q, pgs_q, ppn_q, flg_q};
   assign unused  = ^{w[62:46], cp0_mmu_satp_data[43:0]};

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      idx_d    = idx_q;
      wen_d    = wen_q;
      wdat_d   = wdat_q;
      opasid_d = opasid_q;
      sidx_d   = sidx_q;
      sp_d     = sp_q;
      asid_d   = asid_q;
      pgs_d    = pgs_q;
      vpn_d    = vpn_q;
      ppn_d    = ppn_q;
      flg_d    = flg_q;
      if (cp0_mmu_smir_wen) begin
         sidx_d = w[ENTRY_AW-1:0];
         sp_d   = w[63];
      end
      if (cp0_mmu_smeh_wen) begin
         asid_d = w[15:0];
         pgs_d  = w[18:16];
         vpn_d  = w[45:19];
      end
      if (cp0_mmu_smel_wen) begin
         flg_d = w[13:0];
         ppn_d = w[41:14];
      end
      // TLB results are applied after CSR writes so they win a same-cycle clash
      unique case (state_q)
         IDLE: begin
            if (cp0_mmu_smcir_wen) begin
               state_d  = ISSUE;
               idx_d    = '0;
               wen_d    = 1'b1;
               wdat_d   = new_ent;
               opasid_d = w[15:0];
               if (w[31]) begin
                  op_d  = OP_P;
                  wen_d = 1'b0;
               end else if (w[30]) begin
                  op_d  = OP_R;
                  wen_d = 1'b0;
                  idx_d = sidx_q;
               end else if (w[29]) begin
                  op_d  = OP_WI;
                  idx_d = sidx_q;
               end else if (w[28]) begin
                  op_d  = OP_WR;
                  idx_d = rnd_q;
               end else if (w[26]) begin
                  op_d   = OP_IA;
                  wdat_d = '0;
               end else if (w[25]) begin
                  op_d  = OP_IS;
                  wen_d = 1'b0;
               end else begin
                  state_d = CMPLT;
               end
            end
         end
         ISSUE: begin
            if (tlb_mmu_gnt) begin
               if (!wen_q) begin
                  state_d = WAIT_RD;
               end else if (op_q == OP_WI || op_q == OP_WR || last) begin
                  state_d = CMPLT;
               end else begin
                  idx_d = idx_q + 1'b1;
                  wen_d = (op_q == OP_IA);
               end
            end
         end
         WAIT_RD: begin
            if (tlb_mmu_rvalid) begin
               state_d = ISSUE;
               if (op_q == OP_R) begin
                  vpn_d   = r_vpn;
                  asid_d  = r_asid;
                  pgs_d   = tlb_mmu_rdata[44:42];
                  ppn_d   = tlb_mmu_rdata[41:14];
                  flg_d   = tlb_mmu_rdata[13:0];
                  state_d = CMPLT;
               end else if (op_q == OP_P) begin
                  if (r_hit) begin
                     sidx_d  = idx_q;
                     sp_d    = 1'b0;
                     state_d = CMPLT;
                  end else if (last) begin
                     sp_d    = 1'b1;
                     state_d = CMPLT;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else if (r_vld && r_asid == opasid_q) begin
                  wen_d  = 1'b1;
                  wdat_d = {1'b0, tlb_mmu_rdata[TLB_W-2:0]};
               end else if (last) begin
                  state_d = CMPLT;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         state_q     <= IDLE;
         op_q        <= OP_P;
         idx_q       <= '0;
         rnd_q       <= '0;
         wen_q       <= 1'b0;
         wdat_q      <= '0;
         opasid_q    <= '0;
         sidx_q      <= '0;
         sp_q        <= 1'b0;
         asid_q      <= '0;
         pgs_q       <= '0;
         vpn_q       <= '0;
         ppn_q       <= '0;
         flg_q       <= '0;
         satp_asid_q <= '0;
         satp_mode_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         idx_q    <= idx_d;
         rnd_q    <= rnd_q + 1'b1;
         wen_q    <= wen_d;
         wdat_q   <= wdat_d;
         opasid_q <= opasid_d;
         sidx_q   <= sidx_d;
         sp_q     <= sp_d;
         asid_q   <= asid_d;
         pgs_q    <= pgs_d;
         vpn_q    <= vpn_d;
         ppn_q    <= ppn_d;
         flg_q    <= flg_d;
         if (cp0_mmu_satp_wen) begin
            satp_mode_q <= cp0_mmu_satp_data[63:60];
            satp_asid_q <= cp0_mmu_satp_data[59:44];
         end
      end
   end

   always_comb begin
      mmu_cp0_data = '0;
      unique case (cp0_mmu_csr_sel)
         2'd0: begin
            mmu_cp0_data[63]           = sp_q;
            mmu_cp0_data[ENTRY_AW-1:0] = sidx_q;
         end
         2'd1: mmu_cp0_data = {18'b0, vpn_q, pgs_q, asid_q};
         2'd2: mmu_cp0_data = {22'b0, ppn_q, flg_q};
         default: mmu_cp0_data = '0;
      endcase
   end

   assign mmu_cp0_cmplt = (state_q == CMPLT);
   assign mmu_tlb_req   = (state_q == ISSUE);
   assign mmu_tlb_wen   = wen_q;
   assign mmu_tlb_idx   = idx_q;
   assign mmu_tlb_wdata = wdat_q;
   assign mmu_satp_asid = satp_asid_q;
   assign mmu_satp_mode = satp_mode_q;

endmodule

// File: tb/tb_aq_mmu_smcir_rsp.sv
// tb_aq_mmu_smcir_rsp: random and directed checks of aq_mmu_smcir_rsp
// against a behavioural CSR/jTLB model with a randomised TLB responder.
module tb_aq_mmu_smcir_rsp;
   localparam int N  = 128;
   localparam int AW = 7;
   localparam int TW = 89;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [63:0]   wdata = '0;
   logic          smcir_wen = 0, smir_wen = 0, smeh_wen = 0;
   logic          smel_wen = 0, satp_wen = 0;
   logic [63:0]   satp_data = '0;
   logic [1:0]    csr_sel = '0;
   logic [63:0]   rd_data;
   logic          cmplt;
   logic [15:0]   satp_asid;
   logic [3:0]    satp_mode;
   logic          req, wen;
   logic [AW-1:0] idx;
   logic [TW-1:0] wd;
   logic          gnt, rvalid;
   logic [TW-1:0] rdata;

   aq_mmu_smcir_rsp dut (
      .forever_cpuclk    (clk),
      .cpurst            (rst),
      .cp0_mmu_csr_wdata (wdata),
      .cp0_mmu_smcir_wen (smcir_wen),
      .cp0_mmu_smir_wen  (smir_wen),
      .cp0_mmu_smeh_wen  (smeh_wen),
      .cp0_mmu_smel_wen  (smel_wen),
      .cp0_mmu_satp_wen  (satp_wen),
      .cp0_mmu_satp_data (satp_data),
      .cp0_mmu_csr_sel   (csr_sel),
      .mmu_cp0_data      (rd_data),
      .mmu_cp0_cmplt     (cmplt),
      .mmu_satp_asid     (satp_asid),
      .mmu_satp_mode     (satp_mode),
      .mmu_tlb_req       (req),
      .mmu_tlb_wen       (wen),
      .mmu_tlb_idx       (idx),
      .mmu_tlb_wdata     (wd),
      .tlb_mmu_gnt       (gnt),
      .tlb_mmu_rvalid    (rvalid),
      .tlb_mmu_rdata     (rdata)
   );

   always #5 clk = ~clk;

   typedef logic [96:0] acc_t;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cmplt_cnt = 0;
   int          cyc = 0;
   bit          abort = 0;
   logic [TW-1:0] mem [N];
   logic [TW-1:0] ref_mem [N];
   logic [63:0] m_smir = '0, m_smeh = '0, m_smel = '0;
   acc_t        exp_q[$];
   acc_t        log_q[$];

   int          rd_lat = -1;
   int          stall_left = 0;
   bit          gnt_always = 0;

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(posedge clk or posedge rst)
      if (rst) cyc <= 0;
      else cyc <= cyc + 1;

   always @(negedge clk)
      if (cmplt === 1'b1) cmplt_cnt++;

   // TLB array responder: random gnt, rvalid 1..3 cycles after gnt
   bit            fire = 0;
   logic          f_wen;
   logic [AW-1:0] f_idx;
   logic [TW-1:0] f_wd;
   int            rd_wait = -1;
   logic [AW-1:0] rd_idx;
   bit            hold_pend = 0;
   logic [96:0]   h_acc;

   initial begin
      gnt = 0; rvalid = 0; rdata = '0;
      forever begin
         @(negedge clk);
         rvalid = 1'b0;
         if (rst) begin
            fire = 0; rd_wait = -1; hold_pend = 0; gnt = 0;
         end else begin
            if (fire) begin
               log_q.push_back({f_wen, f_idx, f_wd});
               if (f_wen) mem[f_idx] = f_wd;
               else begin
                  rd_idx  = f_idx;
                  rd_wait = (rd_lat > 0) ? rd_lat - 1
                                         : int'($urandom_range(0, 2));
               end
               fire = 0;
            end
            if (rd_wait == 0) begin
               rvalid = 1'b1; rdata = mem[rd_idx]; rd_wait = -1;
            end else if (rd_wait > 0) rd_wait--;
            if (hold_pend) begin
               chk("hold.req", req, 1'b1);
               chk("hold.fields", {wen, idx, wd}, h_acc);
            end
            gnt = 0;
            if (req) begin
               if (stall_left > 0) stall_left--;
               else if (gnt_always || $urandom_range(0, 1) == 1) gnt = 1;
               if (gnt) begin
                  fire = 1; f_wen = wen; f_idx = idx;
                  f_wd = wen ? wd : '0;
               end
               hold_pend = !gnt;
               h_acc = {wen, idx, wd};
            end else hold_pend = 0;
         end
      end
   end

   function automatic logic [TW-1:0] rnd_ent();
      logic [95:0] r;
      r = {$urandom, $urandom, $urandom};
      return r[TW-1:0];
   endfunction

   task automatic set_ent(input int i, input logic [TW-1:0] e);
      mem[i] = e; ref_mem[i] = e;
   endtask

   task automatic model_cmd(input logic [63:0] c, input logic [AW-1:0] rnd);
      logic [TW-1:0] e;
      logic [AW-1:0] i7;
      int            hit;
      exp_q.delete();
      if (c[31]) begin
         hit = -1;
         for (int i = 0; i < N; i++) begin
            exp_q.push_back({1'b0, 7'(i), 89'b0});
            e = ref_mem[i];
            if (e[88] && e[87:61] == m_smeh[45:19] &&
                e[60:45] == m_smeh[15:0]) begin
               hit = i;
               break;
            end
         end
         if (hit >= 0) m_smir = 64'(hit);
         else m_smir[63] = 1'b1;
      end else if (c[30]) begin
         exp_q.push_back({1'b0, m_smir[6:0], 89'b0});
         e = ref_mem[m_smir[6:0]];
         m_smeh = {18'b0, e[87:61], e[44:42], e[60:45]};
         m_smel = {22'b0, e[41:14], e[13:0]};
      end else if (c[29] || c[28]) begin
         i7 = c[29] ? m_smir[6:0] : rnd;
         e = {1'b1, m_smeh[45:19], m_smeh[15:0], m_smeh[18:16],
              m_smel[41:14], m_smel[13:0]};
         exp_q.push_back({1'b1, i7, e});
         ref_mem[i7] = e;
      end else if (c[26]) begin
         for (int i = 0; i < N; i++) begin
            exp_q.push_back({1'b1, 7'(i), 89'b0});
            ref_mem[i] = '0;
         end
      end else if (c[25]) begin
         for (int i = 0; i < N; i++) begin
            exp_q.push_back({1'b0, 7'(i), 89'b0});
            if (ref_mem[i][88] && ref_mem[i][60:45] == c[15:0]) begin
               ref_mem[i][88] = 1'b0;
               exp_q.push_back({1'b1, 7'(i), ref_mem[i]});
            end
         end
      end
   endtask

   task automatic wr_csr(input int sel, input logic [63:0] d);
      @(negedge clk);
      wdata = d;
      case (sel)
         0: begin smir_wen = 1; m_smir = d & 64'h8000_0000_0000_007F; end
         1: begin smeh_wen = 1; m_smeh = d & 64'h0000_3FFF_FFFF_FFFF; end
         default: begin smel_wen = 1; m_smel = d & 64'h0000_03FF_FFFF_FFFF; end
      endcase
      @(negedge clk);
      smir_wen = 0; smeh_wen = 0; smel_wen = 0;
   endtask

   task automatic wr_satp(input string t, input logic [63:0] d);
      @(negedge clk);
      satp_wen = 1; satp_data = d;
      @(negedge clk);
      satp_wen = 0;
      #1;
      chk({t, ".satp_asid"}, satp_asid, d[59:44]);
      chk({t, ".satp_mode"}, satp_mode, d[63:60]);
   endtask

   task automatic chk_csrs(input string t);
      csr_sel = 2'd0; #1 chk({t, ".smir"}, rd_data, m_smir);
      csr_sel = 2'd1; #1 chk({t, ".smeh"}, rd_data, m_smeh);
      csr_sel = 2'd2; #1 chk({t, ".smel"}, rd_data, m_smel);
      csr_sel = 2'd3; #1 chk({t, ".smcir"}, rd_data, 64'h0);
   endtask

   task automatic do_cmd(input string t, input logic [63:0] c, output int lat);
      int c0;
      @(negedge clk);
      log_q.delete();
      c0 = cmplt_cnt;
      wdata = c; smcir_wen = 1;
      model_cmd(c, 7'(cyc % N));
      lat = 0;
      do begin
         @(negedge clk);
         smcir_wen = 0;
         lat++;
      end while (cmplt !== 1'b1 && lat < 4000);
      chk({t, ".done"}, lat < 4000, 1'b1);
      if (lat >= 4000) abort = 1;
      repeat (2) @(negedge clk);
      chk({t, ".cmplt_cnt"}, cmplt_cnt - c0, 1);
      chk({t, ".nacc"}, log_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
         chk({t, ".acc"}, log_q[i], exp_q[i]);
      chk_csrs(t);
   endtask

   initial begin
      int            lat;
      int            c0;
      int            j, op;
      logic [63:0]   c;
      logic [TW-1:0] e;
      int            bits [7] = '{31, 30, 29, 28, 26, 25, -1};

      for (int i = 0; i < N; i++) set_ent(i, rnd_ent());
      repeat (3) @(negedge clk);
      rst = 0;
      @(negedge clk);
      chk("rst.req", req, 1'b0);
      chk("rst.cmplt", cmplt, 1'b0);
      chk("rst.satp", {satp_mode, satp_asid}, 20'h0);
      chk_csrs("rst");

      // TLBWI with gnt in the same cycle as req
      wr_csr(1, (64'h12345 << 19) | 64'h7);
      wr_csr(2, (64'hABC << 14) | 64'h3F);
      wr_csr(0, 64'd5);
      gnt_always = 1;
      do_cmd("wi", 64'h2000_0000, lat);
      chk("wi.lat", lat, 2);
      if (log_q.size() > 0) begin
         chk("wi.idx", log_q[0][95:89], 7'd5);
         chk("wi.ent", log_q[0][88:0],
             {1'b1, 27'h12345, 16'h7, 3'h0, 28'hABC, 14'h3F});
      end
      gnt_always = 0;

      // probe: hit at 9, then a miss
      for (int i = 0; i < N; i++) begin
         e = rnd_ent(); e[88] = 1'b0; set_ent(i, e);
      end
      e = rnd_ent();
      e[88] = 1'b1; e[87:61] = 27'h12345; e[60:45] = 16'h7;
      set_ent(9, e);
      do_cmd("p_hit", 64'h8000_0000, lat);
      wr_csr(1, (64'h12345 << 19) | 64'h8);
      do_cmd("p_miss", 64'h8000_0000, lat);

      // TLBR with rdata 2 cycles after gnt
      set_ent(3, rnd_ent());
      wr_csr(0, 64'd3);
      rd_lat = 2;
      do_cmd("tlbr", 64'h4000_0000, lat);
      rd_lat = -1;

      // INVASID 7 with entries 2 and 40 matching
      for (int i = 0; i < N; i++) begin
         e = rnd_ent();
         if (e[60:45] == 16'h7) e[60:45] = 16'h8;
         if (i % 5 == 0) e[60:45] = 16'h7;
         if (i % 5 == 0) e[88] = 1'b0;
         set_ent(i, e);
      end
      e = rnd_ent(); e[88] = 1'b1; e[60:45] = 16'h7; set_ent(2, e);
      e = rnd_ent(); e[88] = 1'b1; e[60:45] = 16'h7; set_ent(40, e);
      do_cmd("invasid", 64'h0200_0007, lat);
      chk("invasid.nacc2", log_q.size(), N + 2);

      // INVALL with gnt held off and a mid-command satp write
      stall_left = 5;
      fork
         do_cmd("invall", 64'h0400_0000, lat);
         wr_satp("invall", 64'hA123_4000_0000_0000);
      join

      // reset in the middle of a probe walk
      for (int i = 0; i < N; i++) begin
         e = rnd_ent(); e[88] = 1'b0; set_ent(i, e);
      end
      wr_csr(0, 64'h8000_0000_0000_0011);
      @(negedge clk);
      wdata = 64'h8000_0000; smcir_wen = 1;
      @(negedge clk);
      smcir_wen = 0;
      repeat (20) @(negedge clk);
      c0 = cmplt_cnt;
      rst = 1;
      #1;
      chk("midrst.req", req, 1'b0);
      chk("midrst.cmplt", cmplt, 1'b0);
      repeat (2) @(negedge clk);
      rst = 0;
      m_smir = '0; m_smeh = '0; m_smel = '0;
      repeat (3) @(negedge clk);
      chk("midrst.no_cmplt", cmplt_cnt, c0);
      chk("midrst.satp", {satp_mode, satp_asid}, 20'h0);
      chk_csrs("midrst");

      // smcir with no op bit
      do_cmd("noop", 64'h0000_0000_0800_1234, lat);
      chk("noop.lat", lat, 1);

      // random commands, priority mixes and CSR traffic
      for (int k = 0; k < 40 && !abort; k++) begin
         if ($urandom_range(0, 2) == 0)
            for (int i = 0; i < N; i++) set_ent(i, rnd_ent());
         wr_csr(0, {$urandom, $urandom});
         j = $urandom_range(0, N - 1);
         if ($urandom_range(0, 1) == 1) begin
            e = ref_mem[j]; e[88] = 1'b1; set_ent(j, e);
            wr_csr(1, {18'b0, e[87:61], 3'($urandom), e[60:45]});
         end else wr_csr(1, {$urandom, $urandom});
         wr_csr(2, {$urandom, $urandom});
         c = {$urandom, $urandom};
         c[31:25] = 7'b0;
         c[27] = 1'($urandom);
         op = $urandom_range(0, 6);
         if (bits[op] >= 0) begin
            c[bits[op]] = 1'b1;
            for (int b = 25; b < bits[op]; b++)
               if (b != 27) c[b] = 1'($urandom);
         end
         if (bits[op] == 25 && $urandom_range(0, 1) == 1)
            c[15:0] = ref_mem[j][60:45];
         do_cmd("rnd", c, lat);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
